// File: rtl/aes_bus_pkg.sv
// Shared widths and types for the AES-128 bus requester.
// Job layout puts the key in the upper half of the core input.
package aes_bus_pkg;
  localparam int AES_KEY_W    = 128;
  localparam int AES_BLK_W    = 128;
  localparam int AES_BUS_IN_W = 256;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;

  typedef struct packed {
    logic [AES_KEY_W-1:0] key;
    aes_blk_t             state;
  } aes_job_t;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and flush.
// Head data reads as zero while empty so idle outputs stay quiet.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic [AW:0]      o_count,
  output logic             o_empty,
  output logic             o_full
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dout  = o_empty ? '0 : r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end
endmodule

// File: rtl/aes_bus_requester.sv
// Bus master for the AES-128 core: credit-limited issue, in-order
// tag matching, buffered results, hang and spurious-output detection.
module aes_bus_requester
  import aes_bus_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAG_W           = 4,
  parameter int TIMEOUT         = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [AES_KEY_W-1:0]    job_key,
  input  logic [AES_BLK_W-1:0]    job_state,
  input  logic [TAG_W-1:0]        job_tag,
  output logic [AES_BUS_IN_W-1:0] bus_input,
  output logic                    bus_start,
  input  logic                    bus_ready,
  input  logic [AES_BLK_W-1:0]    bus_output,
  input  logic                    bus_output_valid,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [AES_BLK_W-1:0]    rsp_data,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic                    timeout_err,
  output logic                    spurious_err,
  output logic [15:0]             issued_cnt,
  output logic [15:0]             completed_cnt
);
  localparam int CW   = $clog2(MAX_OUTSTANDING) + 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int RW   = TAG_W + AES_BLK_W;

  aes_job_t        r_job;
  logic            r_start;
  logic [15:0]     r_issued;
  logic [15:0]     r_completed;
  logic            r_timeout;
  logic            r_spurious;
  logic [WD_W-1:0] r_wd;

  logic [CW-1:0]    w_inflight;
  logic [CW-1:0]    w_rsp_cnt;
  logic [CW-1:0]    w_credit;
  logic [TAG_W-1:0] w_tag_head;
  logic [RW-1:0]    w_rsp_dout;
  logic             w_rsp_empty;
  logic             w_accept;
  logic             w_capture;
  logic             w_idle;
  logic             w_wd_clr;
  logic             w_wd_fire;
  logic             w_unused;

  assign w_credit  = CW'(MAX_OUTSTANDING) - (w_inflight + w_rsp_cnt);
  assign w_idle    = (w_inflight == '0);
  assign w_wd_clr  = bus_output_valid || w_idle;
  assign w_wd_fire = !w_wd_clr && (r_wd == WD_W'(TIMEOUT - 1));

  // Block issue in the flush cycle so no tag is lost to the flush.
  assign job_ready = !rst && bus_ready && (w_credit != '0)
                   && !r_timeout && !w_wd_fire;
  assign w_accept  = job_valid && job_ready;
  assign w_capture = bus_output_valid && !w_idle;

  sync_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk     (clk),
    .i_rst   (rst),
    .i_flush (w_wd_fire),
    .i_push  (w_accept),
    .i_din   (job_tag),
    .i_pop   (w_capture),
    .o_dout  (w_tag_head),
    .o_count (w_inflight),
    .o_empty (),
    .o_full  ()
  );

  sync_fifo #(.WIDTH(RW), .DEPTH(MAX_OUTSTANDING)) u_rsp_fifo (
    .clk     (clk),
    .i_rst   (rst),
    .i_flush (1'b0),
    .i_push  (w_capture),
    .i_din   ({w_tag_head, bus_output}),
    .i_pop   (rsp_ready),
    .o_dout  (w_rsp_dout),
    .o_count (w_rsp_cnt),
    .o_empty (w_rsp_empty),
    .o_full  (w_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_job       <= '0;
      r_start     <= 1'b0;
      r_issued    <= '0;
      r_completed <= '0;
      r_timeout   <= 1'b0;
      r_spurious  <= 1'b0;
      r_wd        <= '0;
    end else begin
      r_start <= w_accept;
      if (w_accept) begin
        r_job    <= '{key: job_key, state: job_state};
        r_issued <= r_issued + 16'd1;
      end
      if (w_capture) r_completed <= r_completed + 16'd1;
      if (bus_output_valid && w_idle) r_spurious <= 1'b1;
      if (w_wd_fire) r_timeout <= 1'b1;
      if (w_wd_clr || w_wd_fire) r_wd <= '0;
      else                       r_wd <= r_wd + 1'b1;
    end
  end

  assign bus_input     = r_job;
  assign bus_start     = r_start;
  assign rsp_valid     = !w_rsp_empty;
  assign rsp_data      = w_rsp_dout[AES_BLK_W-1:0];
  assign rsp_tag       = w_rsp_dout[RW-1:AES_BLK_W];
  assign timeout_err   = r_timeout;
  assign spurious_err  = r_spurious;
  assign issued_cnt    = r_issued;
  assign completed_cnt = r_completed;
endmodule
